// File: rtl/set_point_counter.sv
// Grid-scan counting engine for the SET datapath. Walks the 8x8 lattice one point per
// cycle and counts the points that satisfy the selected circle set expression.
//
// state | meaning
// IDLE  | waiting for start_i; candidate_o holds the last result
// SCAN  | evaluating lattice point p (x = p[2:0]+1, y = p[5:3]+1), one per cycle
// DONE  | one-cycle valid/done pulse with the final count
module set_point_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic [23:0] central_i,
  input  logic [11:0] r_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic        done_o,
  output logic [7:0]  candidate_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  p;
  logic [7:0]  count;
  logic [1:0]  mode_q;

  logic [3:0]  px;
  logic [3:0]  py;
  logic        in_a;
  logic        in_b;
  logic        in_c;
  logic        qualify;
  logic [7:0]  count_next;

  // Inclusive membership test: squares are 8 bits, their sum 9 bits, compared unsigned.
  function automatic logic in_circle(input logic [3:0] x, input logic [3:0] y,
                                     input logic [3:0] cx, input logic [3:0] cy,
                                     input logic [3:0] r);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] sx;
    logic [7:0] sy;
    logic [7:0] r2;
    logic [8:0] sum;
    dx  = (x >= cx) ? (x - cx) : (cx - x);
    dy  = (y >= cy) ? (y - cy) : (cy - y);
    sx  = {4'b0000, dx} * {4'b0000, dx};
    sy  = {4'b0000, dy} * {4'b0000, dy};
    r2  = {4'b0000, r} * {4'b0000, r};
    sum = {1'b0, sx} + {1'b0, sy};
    return (sum <= {1'b0, r2});
  endfunction

  always_comb begin
    px   = {1'b0, p[2:0]} + 4'd1;
    py   = {1'b0, p[5:3]} + 4'd1;
    in_a = in_circle(px, py, central_i[23:20], central_i[19:16], r_i[11:8]);
    in_b = in_circle(px, py, central_i[15:12], central_i[11:8],  r_i[7:4]);
    in_c = in_circle(px, py, central_i[7:4],   central_i[3:0],   r_i[3:0]);
    qualify = 1'b0;
    case (mode_q)
      2'b00:   qualify = in_a;
      2'b01:   qualify = in_a & in_b;
      2'b10:   qualify = in_a ^ in_b;
      default: qualify = (in_a & in_b & ~in_c) | (in_a & ~in_b & in_c) | (~in_a & in_b & in_c);
    endcase
    count_next = count + {7'b0000000, qualify};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      p           <= 6'd0;
      count       <= 8'd0;
      mode_q      <= 2'b00;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
      done_o      <= 1'b0;
      candidate_o <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          done_o  <= 1'b0;
          if (start_i) begin
            state  <= SCAN;
            p      <= 6'd0;
            count  <= 8'd0;
            mode_q <= mode_i;
            busy_o <= 1'b1;
          end
        end
        SCAN: begin
          p     <= p + 6'd1;
          count <= count_next;
          if (p == 6'd63) begin
            state       <= DONE;
            busy_o      <= 1'b0;
            valid_o     <= 1'b1;
            done_o      <= 1'b1;
            candidate_o <= count_next;
          end
        end
        DONE: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          done_o  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_point_counter.sv
// Bench for set_point_counter: cycle-level behavioural model checked every cycle,
// plus directed scans with hand-computed counts.
module tb_set_point_counter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'b00;
  logic [23:0] central_i = 24'd0;
  logic [11:0] r_i = 12'd0;
  logic        busy_o;
  logic        valid_o;
  logic        done_o;
  logic [7:0]  candidate_o;

  int n_cmp = 0;
  int n_err = 0;

  set_point_counter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .central_i   (central_i),
    .r_i         (r_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .done_o      (done_o),
    .candidate_o (candidate_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Count from plain geometry over the lattice with full-precision integers.
  function automatic int expected_count(input logic [1:0] mode, input logic [23:0] c,
                                        input logic [11:0] r);
    int cx [3];
    int cy [3];
    int rr [3];
    int total;
    total = 0;
    for (int k = 0; k < 3; k++) begin
      cx[k] = int'(c[23 - 8*k -: 4]);
      cy[k] = int'(c[19 - 8*k -: 4]);
      rr[k] = int'(r[11 - 4*k -: 4]);
    end
    for (int x = 1; x <= 8; x++) begin
      for (int y = 1; y <= 8; y++) begin
        int hit [3];
        for (int k = 0; k < 3; k++)
          hit[k] = (((x - cx[k]) * (x - cx[k]) + (y - cy[k]) * (y - cy[k])) <= rr[k] * rr[k]) ? 1 : 0;
        case (mode)
          2'b00: total += hit[0];
          2'b01: total += hit[0] & hit[1];
          2'b10: total += (hit[0] + hit[1] == 1) ? 1 : 0;
          default: total += (hit[0] + hit[1] + hit[2] == 2) ? 1 : 0;
        endcase
      end
    end
    return total;
  endfunction

  // Model: cycles since accepted start (-1 = idle). 0..63 scanning, 64 = result cycle.
  int m_phase = -1;
  int m_pending = 0;
  int m_cand = 0;
  bit m_live = 1'b0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_phase <= -1;
      m_cand  <= 0;
      m_live  <= 1'b1;
    end else if (m_phase == -1) begin
      if (start_i) begin
        m_phase   <= 0;
        m_pending <= expected_count(mode_i, central_i, r_i);
      end
    end else if (m_phase == 63) begin
      m_phase <= 64;
      m_cand  <= m_pending;
    end else if (m_phase == 64) begin
      m_phase <= -1;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk_i) begin
    if (m_live) begin
      check("busy", int'(busy_o), (m_phase >= 0 && m_phase <= 63) ? 1 : 0);
      check("valid", int'(valid_o), (m_phase == 64) ? 1 : 0);
      check("done", int'(done_o), (m_phase == 64) ? 1 : 0);
      check("candidate", int'(candidate_o), m_cand);
    end
  end

  task automatic run_scan(input string name, input logic [1:0] mode, input logic [23:0] c,
                          input logic [11:0] r, input int hand, input bit toggle);
    bit seen;
    int busy_cycles;
    seen = 1'b0;
    busy_cycles = 0;
    check({name, "_model"}, expected_count(mode, c, r), hand);
    @(negedge clk_i);
    mode_i    = mode;
    central_i = c;
    r_i       = r;
    start_i   = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
      if (busy_o) busy_cycles++;
      if (toggle) start_i = (i < 40) ? i[0] : 1'b0;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    check({name, "_valid_seen"}, int'(seen), 1);
    check({name, "_result"}, int'(candidate_o), hand);
    check({name, "_busy_len"}, busy_cycles, 64);
    @(negedge clk_i);
    check({name, "_pulse_len"}, int'(valid_o), 0);
    @(negedge clk_i);
  endtask

  initial begin
    int pulses;
    int good;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check("reset_candidate", int'(candidate_o), 0);
    check("reset_busy", int'(busy_o), 0);

    run_scan("a_r1",      2'b00, 24'h44_00_00, 12'h100, 5,  1'b0);
    run_scan("a_r8",      2'b00, 24'h44_00_00, 12'h800, 64, 1'b0);
    run_scan("a_offgrid", 2'b00, 24'h00_00_00, 12'h000, 0,  1'b0);
    run_scan("and_b0",    2'b01, 24'h44_44_00, 12'h800, 1,  1'b1);
    run_scan("xor_b0",    2'b10, 24'h44_44_00, 12'h800, 63, 1'b0);
    run_scan("two_of",    2'b11, 24'h44_44_FF, 12'h110, 5,  1'b0);
    run_scan("xor_same",  2'b10, 24'h44_44_00, 12'h110, 0,  1'b0);
    run_scan("edge_r3",   2'b00, 24'h11_00_00, 12'h300, 11, 1'b0);

    // Reset in the middle of a scan.
    @(negedge clk_i);
    mode_i = 2'b00; central_i = 24'h44_00_00; r_i = 12'h100; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (29) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_valid", int'(valid_o), 0);
    check("midrst_candidate", int'(candidate_o), 0);
    run_scan("after_rst", 2'b00, 24'h44_00_00, 12'h100, 5, 1'b0);

    // start_i held high: scans repeat, each yielding 5.
    @(negedge clk_i);
    mode_i = 2'b00; central_i = 24'h44_00_00; r_i = 12'h100; start_i = 1'b1;
    pulses = 0;
    good = 0;
    for (int i = 0; i < 205; i++) begin
      @(negedge clk_i);
      if (valid_o) begin
        pulses++;
        if (candidate_o == 8'd5) good++;
      end
    end
    start_i = 1'b0;
    check("held_pulses", pulses, 3);
    check("held_results", good, 3);
    repeat (80) @(negedge clk_i);
    check("final_idle_busy", int'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
